// File: rtl/upower_fetch_decode.sv
// Single-issue fetch/decode front end for D-format uPower instructions.
// It fetches one word at a time, decodes PO/rt/ra/SI, and hands the result to a valid/ready consumer.
module upower_fetch_decode #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  PO,
    output logic [4:0]  rt,
    output logic [4:0]  ra,
    output logic [47:0] SI,
    output logic [63:0] out_pc,
    output logic        d_form,
    output logic [31:0] instr_count
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_OUT,
        S_DRAIN
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [63:0] addr_q, addr_d;
    logic        valid_q, valid_d;
    logic [5:0]  po_q, po_d;
    logic [4:0]  rt_q, rt_d;
    logic [4:0]  ra_q, ra_d;
    logic [47:0] si_q, si_d;
    logic [63:0] out_pc_q, out_pc_d;
    logic        d_form_q, d_form_d;
    logic [31:0] count_q, count_d;

    logic [5:0]  dec_po;
    logic        dec_d_form;
    logic [63:0] pc_next_seq;

    assign dec_po      = imem_rdata[31:26];
    assign dec_d_form  = (dec_po == 6'd14) || (dec_po == 6'd15) || (dec_po == 6'd24) ||
                         (dec_po == 6'd26) || (dec_po == 6'd28);
    assign pc_next_seq = pc_q + 64'd4;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
        state_d  = state_q;
        pc_d     = pc_q;
        req_d    = req_q;
        addr_d   = addr_q;
        valid_d  = valid_q;
        po_d     = po_q;
        rt_d     = rt_q;
        ra_d     = ra_q;
        si_d     = si_q;
        out_pc_d = out_pc_q;
        d_form_d = d_form_q;
        count_d  = count_q;

        unique case (state_q)
            S_FETCH: begin
                if (!req_q) begin
                    // First cycle out of reset: launch the request, honouring an early redirect.
                    pc_d   = redirect_valid ? redirect_pc : pc_q;
                    addr_d = pc_d;
                    req_d  = 1'b1;
                end else if (redirect_valid) begin
                    pc_d = redirect_pc;
                    if (imem_ack) begin
                        addr_d = redirect_pc;
                    end else begin
                        // The stale request is still in flight; keep it stable until it returns.
                        state_d = S_DRAIN;
                    end
                end else if (imem_ack) begin
                    po_d     = dec_po;
                    rt_d     = imem_rdata[25:21];
                    ra_d     = imem_rdata[20:16];
                    si_d     = {{32{imem_rdata[15]}}, imem_rdata[15:0]};
                    d_form_d = dec_d_form;
                    out_pc_d = pc_q;
                    pc_d     = pc_next_seq;
                    valid_d  = 1'b1;
                    req_d    = 1'b0;
                    state_d  = S_OUT;
                end
            end
            S_OUT: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    addr_d  = redirect_pc;
                    valid_d = 1'b0;
                    req_d   = 1'b1;
                    state_d = S_FETCH;
                end else if (out_ready) begin
                    count_d = count_q + 32'd1;
                    addr_d  = pc_q;
                    valid_d = 1'b0;
                    req_d   = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end
                if (imem_ack) begin
                    addr_d  = pc_d;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            req_q    <= 1'b0;
            addr_q   <= RESET_PC;
            valid_q  <= 1'b0;
            po_q     <= '0;
            rt_q     <= '0;
            ra_q     <= '0;
            si_q     <= '0;
            out_pc_q <= '0;
            d_form_q <= 1'b0;
            count_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values computed above.
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            valid_q  <= valid_d;
            po_q     <= po_d;
            rt_q     <= rt_d;
            ra_q     <= ra_d;
            si_q     <= si_d;
            out_pc_q <= out_pc_d;
            d_form_q <= d_form_d;
            count_q  <= count_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign out_valid   = valid_q;
    assign PO          = po_q;
    assign rt          = rt_q;
    assign ra          = ra_q;
    assign SI          = si_q;
    assign out_pc      = out_pc_q;
    assign d_form      = d_form_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_upower_fetch_decode.sv
// Directed bench for upower_fetch_decode: hand-computed expectations for decode, handshake,
// redirect and reset behaviour.
module tb_upower_fetch_decode;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  PO;
    logic [4:0]  rt;
    logic [4:0]  ra;
    logic [47:0] SI;
    logic [63:0] out_pc;
    logic        d_form;
    logic [31:0] instr_count;

    int checks = 0;
    int errors = 0;

    upower_fetch_decode #(.RESET_PC(64'h0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .PO             (PO),
        .rt             (rt),
        .ra             (ra),
        .SI             (SI),
        .out_pc         (out_pc),
        .d_form         (d_form),
        .instr_count    (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [5:0]  hold_po;
    logic [47:0] hold_si;
    logic [63:0] hold_pc;

    initial begin
        rst_n          = 1'b1;
        imem_ack       = 1'b0;
        imem_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check("rst_req",   imem_req,    0);
        check("rst_valid", out_valid,   0);
        check("rst_count", instr_count, 0);
        check("rst_po",    PO,          0);
        check("rst_si",    SI,          0);
        check("rst_outpc", out_pc,      0);

        // Ack during reset must be ignored.
        imem_ack   = 1'b1;
        imem_rdata = 32'h3862FFFF;
        step();
        step();
        check("rst_ack_ignored_req",   imem_req,  0);
        check("rst_ack_ignored_valid", out_valid, 0);
        imem_ack = 1'b0;
        rst_n    = 1'b1;

        // First posedge after release launches the fetch at RESET_PC.
        step();
        check("first_req",  imem_req,  1);
        check("first_addr", imem_addr, 64'h0);
        step();
        check("wait_req",  imem_req,  1);
        check("wait_addr", imem_addr, 64'h0);
        check("wait_valid", out_valid, 0);

        // addi r3,r2,-1
        imem_ack   = 1'b1;
        imem_rdata = 32'h3862FFFF;
        step();
        imem_ack = 1'b0;
        check("dec0_valid", out_valid, 1);
        check("dec0_req",   imem_req,  0);
        check("dec0_po",    PO,        14);
        check("dec0_rt",    rt,        3);
        check("dec0_ra",    ra,        2);
        check("dec0_si",    SI,        48'hFFFF_FFFF_FFFF);
        check("dec0_dform", d_form,    1);
        check("dec0_outpc", out_pc,    64'h0);

        // Back-pressure: everything holds while out_ready is low.
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_valid", out_valid, 1);
            check("hold_req",   imem_req,  0);
            check("hold_po",    PO,        14);
            check("hold_si",    SI,        48'hFFFF_FFFF_FFFF);
            check("hold_count", instr_count, 0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("xfer0_valid", out_valid,   0);
        check("xfer0_count", instr_count, 1);
        check("xfer0_req",   imem_req,    1);
        check("xfer0_addr",  imem_addr,   64'h4);

        // Redirect while the request is outstanding: drain, then refetch at 0x100.
        redirect_valid = 1'b1;
        redirect_pc    = 64'h100;
        step();
        redirect_valid = 1'b0;
        check("drain_req",  imem_req,  1);
        check("drain_addr", imem_addr, 64'h4);
        step();
        step();
        check("drain2_addr",  imem_addr, 64'h4);
        check("drain2_valid", out_valid, 0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h3862FFFF;
        step();
        imem_ack = 1'b0;
        check("drained_valid", out_valid, 0);
        check("drained_req",   imem_req,  1);
        check("drained_addr",  imem_addr, 64'h100);

        // addi r5,r4,16 fetched from 0x100.
        imem_ack   = 1'b1;
        imem_rdata = 32'h38A40010;
        step();
        imem_ack = 1'b0;
        check("dec1_valid", out_valid, 1);
        check("dec1_rt",    rt,        5);
        check("dec1_ra",    ra,        4);
        check("dec1_si",    SI,        48'h10);
        check("dec1_outpc", out_pc,    64'h100);

        // Redirect in OUT with out_ready: not a transfer.
        redirect_valid = 1'b1;
        redirect_pc    = 64'h200;
        out_ready      = 1'b1;
        step();
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        check("rdout_valid", out_valid,   0);
        check("rdout_count", instr_count, 1);
        check("rdout_req",   imem_req,    1);
        check("rdout_addr",  imem_addr,   64'h200);

        // Redirect coinciding with ack in FETCH: data dropped, refetch at top of memory.
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        imem_ack       = 1'b1;
        imem_rdata     = 32'h3862FFFF;
        step();
        redirect_valid = 1'b0;
        check("rdack_valid", out_valid, 0);
        check("rdack_req",   imem_req,  1);
        check("rdack_addr",  imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);

        // Non-D-form opcode 31 at the wrap boundary.
        imem_rdata = 32'h7C000000;
        step();
        imem_ack = 1'b0;
        check("dec2_valid", out_valid, 1);
        check("dec2_po",    PO,        31);
        check("dec2_dform", d_form,    0);
        check("dec2_outpc", out_pc,    64'hFFFF_FFFF_FFFF_FFFC);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("wrap_count", instr_count, 2);
        check("wrap_addr",  imem_addr,   64'h0);

        // ori (PO 24) with a negative immediate.
        imem_ack   = 1'b1;
        imem_rdata = 32'h6000_8000;
        step();
        imem_ack = 1'b0;
        check("dec3_po",    PO,     24);
        check("dec3_dform", d_form, 1);
        check("dec3_si",    SI,     48'hFFFF_FFFF_8000);
        check("dec3_outpc", out_pc, 64'h0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("xfer3_count", instr_count, 3);
        check("xfer3_addr",  imem_addr,   64'h4);

        // Asynchronous reset in the middle of an outstanding fetch.
        step();
        #2 rst_n = 1'b0;
        #1;
        check("arst_req",   imem_req,    0);
        check("arst_count", instr_count, 0);
        check("arst_po",    PO,          0);
        check("arst_addr",  imem_addr,   64'h0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h3C000000;
        step();
        check("arst_ack_valid", out_valid, 0);
        imem_ack = 1'b0;
        rst_n    = 1'b1;
        step();
        check("refetch_req",  imem_req,  1);
        check("refetch_addr", imem_addr, 64'h0);

        // addis (PO 15) confirms the restarted fetch decodes from RESET_PC.
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        check("dec4_valid", out_valid, 1);
        check("dec4_po",    PO,        15);
        check("dec4_dform", d_form,    1);
        check("dec4_outpc", out_pc,    64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/upower_fetch_decode.md
UPOWER_FETCH_DECODE -- requirements
Module: upower_fetch_decode

Interface
REQ-001 Parameter RESET_PC, default 64'h0: PC value loaded on reset.
REQ-002 Port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port imem_req  output  1  instruction-memory read request.
REQ-005 Port imem_addr  output  64  byte address of the requested word.
REQ-006 Port imem_ack  input  1  memory has returned data this cycle.
REQ-007 Port imem_rdata  input  32  instruction word; valid only when imem_ack=1.
REQ-008 Port redirect_valid  input  1  flush and restart fetch (branch/exception).
REQ-009 Port redirect_pc  input  64  restart address; sampled when redirect_valid=1.
REQ-010 Port out_valid  output  1  decoded fields below are valid.
REQ-011 Port out_ready  input  1  downstream D-format execute stage accepts.
REQ-012 Port PO  output  6  primary opcode, instr[31:26].
REQ-013 Port rt  output  5  target register, instr[25:21].
REQ-014 Port ra  output  5  source register, instr[20:16].
REQ-015 Port SI  output  48  instr[15:0] sign-extended to 48 bits.
REQ-016 Port out_pc  output  64  address the delivered instruction was fetched from.
REQ-017 Port d_form  output  1  1 when PO is 14, 15, 24, 26 or 28; otherwise 0.
REQ-018 Port instr_count  output  32  count of completed output transfers.

Function
REQ-019 The block SHALL implement three states: FETCH, OUT and DRAIN.
REQ-020 FETCH: imem_req=1 and imem_addr=pc; imem_addr SHALL stay stable while imem_req=1 and imem_ack=0.
REQ-021 FETCH with imem_ack=1 and no redirect: the block SHALL register PO, rt, ra, SI, d_form, out_pc<=pc and pc<=pc+4 (64-bit wrap), SHALL set out_valid=1 and SHALL go to OUT.
REQ-022 OUT: imem_req=0; outputs SHALL hold unchanged until out_valid&out_ready.
REQ-023 OUT with out_ready=1 and no redirect: out_valid SHALL drop to 0, instr_count SHALL increment by 1 (32-bit wrap) and the state SHALL return to FETCH.
REQ-024 The fetch-to-out latency SHALL be one cycle: out_valid rises on the cycle after the imem_ack cycle, and the next imem_req rises on the cycle after the transfer.
REQ-025 Redirect has priority over every other event.
REQ-026 Redirect in FETCH with imem_ack=1: the data SHALL be discarded, pc<=redirect_pc and the state SHALL stay FETCH.
REQ-027 Redirect in FETCH with imem_ack=0: the state SHALL go to DRAIN, imem_req and imem_addr SHALL be held, and pc<=redirect_pc.
REQ-028 DRAIN: on imem_ack the data SHALL be discarded and the state SHALL go to FETCH; a further redirect in DRAIN SHALL overwrite pc only.
REQ-029 Redirect in OUT: out_valid SHALL drop to 0 next cycle, pc<=redirect_pc and the state SHALL go to FETCH; out_valid&out_ready in a redirect cycle SHALL NOT count as a transfer and instr_count SHALL NOT increment.
REQ-030 out_valid SHALL never be 1 while imem_req=1.

Reset
REQ-031 With rst_n=0, immediately and independent of clk: state=FETCH, pc=RESET_PC, out_valid=0, imem_req=0, PO/rt/ra/SI/out_pc/d_form=0, instr_count=0.
REQ-032 imem_req SHALL first assert on the first posedge after rst_n rises.
REQ-033 Reset mid-request SHALL abandon the outstanding request, and any imem_ack during reset SHALL be ignored.

Verification
REQ-034 After reset, imem_ack=1 on the 2nd cycle with rdata 32'h3862FFFF (addi r3,r2,-1) -> PO=14, rt=3, ra=2, SI=48'hFFFFFFFFFFFF, d_form=1, out_pc=0, next imem_addr=4.
REQ-035 out_ready held 0 for 5 cycles in OUT -> all outputs stable and imem_req=0; out_ready=1 -> instr_count=1, then FETCH.
REQ-036 Redirect to 0x100 in FETCH, ack arriving 3 cycles later -> DRAIN, data dropped, next imem_addr=0x100, no out_valid.
REQ-037 Redirect to 0x200 in OUT with out_ready=1 -> instr_count unchanged, out_valid=0, next imem_addr=0x200.
REQ-038 pc=64'hFFFF_FFFF_FFFF_FFFC fetched -> next imem_addr=0; rdata 32'h7C000000 (PO=31) -> d_form=0.
REQ-039 rst_n pulsed low mid-FETCH -> outputs reset asynchronously and the refetch starts at RESET_PC.
